// File: rtl/key_irq_servicer_pkg.sv
// Shared constants and FSM encoding for the key PIO interrupt servicer.
package key_svc_pkg;

    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE = 2'd3;

    localparam int DROP_W = 8;

    typedef enum logic [2:0] {
        INIT_MASK,
        IDLE,
        RD_ADDR,
        RD_DATA,
        CLR,
        SETTLE
    } svc_state_e;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO; pointers carry a wrap bit so full and empty are unambiguous.
module key_evt_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push, do_pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_data = mem_q[rd_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
        rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/key_irq_servicer.sv
// Avalon-MM initiator that programs the key PIO mask, services its interrupt by
// reading and clearing edge-capture, and queues timestamped key events.
//
// state     | meaning
// INIT_MASK | write irq mask to the PIO (entered only from reset)
// IDLE      | bus idle, waiting for irq_in
// RD_ADDR   | read of edge-capture is on the bus
// RD_DATA   | read data returns; keys and timestamp captured
// CLR       | clear write on the bus; event pushed if any key bit set
// SETTLE    | bus idle so irq_in reflects the cleared edge-capture
module key_irq_servicer
    import key_svc_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MASK  = 4'hF,
    parameter int               TS_W  = 16,
    parameter int               DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  irq_in,
    output logic [1:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [TS_W+WIDTH-1:0] ev_data,
    output logic [DROP_W-1:0]     drop_count,
    output logic                  busy
);
    svc_state_e        state_q, state_d;
    logic [1:0]        addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  keys_q, keys_d;
    logic [TS_W-1:0]   ts_lat_q, ts_lat_d;
    logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              push, fifo_full, fifo_empty;
    logic              unused_rd_hi;

    assign unused_rd_hi = ^avm_readdata[31:WIDTH];

    // Bus outputs are registered alongside the state they belong to.
    always_comb begin
        state_d  = state_q;
        addr_d   = PIO_DATA;
        cs_d     = 1'b0;
        wn_d     = 1'b1;
        wdata_d  = '0;
        keys_d   = keys_q;
        ts_lat_d = ts_lat_q;
        unique case (state_q)
            INIT_MASK: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = PIO_MASK;
                wdata_d = 32'(MASK);
            end
            IDLE: begin
                if (irq_in) begin
                    state_d = RD_ADDR;
                    cs_d    = 1'b1;
                    addr_d  = PIO_EDGE;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                keys_d   = avm_readdata[WIDTH-1:0] & MASK;
                ts_lat_d = ts_cnt_q;
                state_d  = CLR;
                cs_d     = 1'b1;
                wn_d     = 1'b0;
                addr_d   = PIO_EDGE;
                wdata_d  = 32'(keys_d);
            end
            CLR:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = INIT_MASK;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        push     = (state_q == CLR) && (keys_q != '0);
        ts_cnt_d = ts_cnt_q + TS_W'(1);
        drop_d   = drop_q;
        if (push && fifo_full && !ev_ready && drop_q != '1)
            drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT_MASK;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            keys_q   <= '0;
            ts_lat_q <= '0;
            ts_cnt_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            keys_q   <= keys_d;
            ts_lat_q <= ts_lat_d;
            ts_cnt_q <= ts_cnt_d;
            drop_q   <= drop_d;
        end
    end

    key_evt_fifo #(
        .W     (TS_W + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({ts_lat_q, keys_q}),
        .pop       (ev_ready),
        .pop_data  (ev_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wdata_q;
    assign ev_valid       = !fifo_empty;
    assign drop_count     = drop_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_key_irq_servicer.sv
// Directed bench for key_irq_servicer with a behavioural key PIO and an event scoreboard.
module tb_key_irq_servicer;

    logic        clk;
    logic        reset;
    logic        irq_in;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        ev_valid;
    logic        ev_ready;
    logic [19:0] ev_data;
    logic [7:0]  drop_count;
    logic        busy;

    logic [3:0]  inject;
    logic        irq_force;
    logic [3:0]  pio_ec;
    logic [3:0]  pio_msk;
    logic [15:0] tb_ts;
    logic [19:0] exp_q[$];
    int          exp_drop;
    int          n_assert;
    int          n_fail;

    key_irq_servicer dut (
        .clk            (clk),
        .reset          (reset),
        .irq_in         (irq_in),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_data        (ev_data),
        .drop_count     (drop_count),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key PIO responder: read latency 1, any write to offset 3 clears edge-capture.
    always @(posedge clk) begin
        if (reset) begin
            pio_ec       <= 4'd0;
            pio_msk      <= 4'd0;
            avm_readdata <= 32'd0;
        end else begin
            if (avm_chipselect && avm_write_n)
                avm_readdata <= (avm_address == 2'd3) ? {28'd0, pio_ec} :
                                (avm_address == 2'd2) ? {28'd0, pio_msk} : 32'd0;
            else
                avm_readdata <= 32'd0;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
                pio_msk <= avm_writedata[3:0];
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
                pio_ec <= inject;
            else
                pio_ec <= pio_ec | inject;
        end
    end

    assign irq_in = (|(pio_ec & pio_msk)) | irq_force;

    always @(posedge clk) begin
        if (reset) tb_ts <= 16'd0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals;
        chk("rst_cs",    32'(avm_chipselect), 32'd0);
        chk("rst_wn",    32'(avm_write_n),    32'd1);
        chk("rst_addr",  32'(avm_address),    32'd0);
        chk("rst_wdata", avm_writedata,       32'd0);
        chk("rst_valid", 32'(ev_valid),       32'd0);
        chk("rst_data",  32'(ev_data),        32'd0);
        chk("rst_drop",  32'(drop_count),     32'd0);
        chk("rst_busy",  32'(busy),           32'd0);
    endtask

    task automatic chk_init_write;
        chk("init_cs",    32'(avm_chipselect), 32'd1);
        chk("init_wn",    32'(avm_write_n),    32'd0);
        chk("init_addr",  32'(avm_address),    32'd2);
        chk("init_wdata", avm_writedata,       32'h0000_000F);
        chk("init_busy",  32'(busy),           32'd0);
    endtask

    task automatic wait_ts(input logic [15:0] t);
        for (int g = 0; g < 70000 && tb_ts != t; g++) tick;
        chk("wait_ts", 32'(tb_ts), 32'(t));
    endtask

    // One full interrupt service starting at a negedge with the DUT in IDLE.
    // k==0 forces irq_in for one cycle to model a spurious interrupt.
    task automatic service(input logic [3:0] k, input bit rdy_at_clr);
        logic [19:0] exp_ev;
        logic [19:0] head;
        inject = k;
        tick;
        inject = 4'd0;
        if (k == 4'd0) irq_force = 1'b1;
        tick;
        irq_force = 1'b0;
        chk("rd_cs",   32'(avm_chipselect), 32'd1);
        chk("rd_wn",   32'(avm_write_n),    32'd1);
        chk("rd_addr", 32'(avm_address),    32'd3);
        chk("rd_busy", 32'(busy),           32'd1);
        tick;
        exp_ev = {tb_ts, k};
        if (k != 4'd0) begin
            if (exp_q.size() < 8 || rdy_at_clr) exp_q.push_back(exp_ev);
            else if (exp_drop < 255) exp_drop++;
        end
        tick;
        chk("clr_cs",    32'(avm_chipselect), 32'd1);
        chk("clr_wn",    32'(avm_write_n),    32'd0);
        chk("clr_addr",  32'(avm_address),    32'd3);
        chk("clr_wdata", avm_writedata,       32'(k));
        if (rdy_at_clr) begin
            head = exp_q.pop_front();
            chk("full_pop_data", 32'(ev_data), 32'(head));
            ev_ready = 1'b1;
        end
        tick;
        ev_ready = 1'b0;
        chk("settle_cs", 32'(avm_chipselect), 32'd0);
        chk("drop",      32'(drop_count),     32'(exp_drop));
        tick;
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic drain;
        logic [19:0] e;
        for (int i = 0; i < 16 && exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            chk("drain_valid", 32'(ev_valid), 32'd1);
            chk("drain_data",  32'(ev_data),  32'(e));
            ev_ready = 1'b1;
            tick;
        end
        ev_ready = 1'b0;
        chk("drained_valid", 32'(ev_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        inject    = 4'd0;
        irq_force = 1'b0;
        ev_ready  = 1'b0;
        exp_drop  = 0;
        n_assert  = 0;
        n_fail    = 0;

        repeat (3) tick;
        chk_reset_vals();
        reset = 1'b0;
        tick;
        chk_init_write();
        tick;
        chk("post_init_cs",   32'(avm_chipselect), 32'd0);
        chk("post_init_busy", 32'(busy),           32'd0);

        // irq seen in IDLE at ts 0x0010, timestamp latched two cycles later
        wait_ts(16'h000F);
        service(4'b0101, 1'b0);
        chk("first_valid", 32'(ev_valid), 32'd1);
        chk("first_data",  32'(ev_data),  32'h0012_5);
        drain();

        service(4'b0000, 1'b0);
        chk("spurious_valid", 32'(ev_valid), 32'd0);

        for (int i = 0; i < 10; i++) service(4'(i + 1), 1'b0);
        chk("ovf_drop",  32'(drop_count), 32'd2);
        chk("ovf_valid", 32'(ev_valid),   32'd1);
        service(4'hC, 1'b1);
        chk("full_push_drop", 32'(drop_count), 32'd2);
        drain();

        // RD_DATA lands on the cycle the timestamp wraps to zero
        wait_ts(16'hFFFD);
        service(4'b1000, 1'b0);
        chk("wrap_ts", 32'(ev_data[19:4]), 32'd0);
        drain();

        // Leave an event queued, then reset while in RD_DATA
        service(4'b0011, 1'b0);
        chk("pre_rst_valid", 32'(ev_valid), 32'd1);
        inject = 4'b0110;
        tick;
        inject = 4'd0;
        tick;
        tick;
        reset = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        tick;
        chk_reset_vals();
        reset = 1'b0;
        tick;
        chk_init_write();
        tick;
        chk("post_rst_idle_cs", 32'(avm_chipselect), 32'd0);
        chk("post_rst_valid",   32'(ev_valid),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
